// File: rtl/vector_player_checker.sv
// Replays a directed {stim, expected} table, then LFSR vectors, into a block under test;
// directed responses are checked one cycle after acceptance.
module vector_player_checker #(
  parameter int unsigned STIM_WIDTH = 15,
  parameter int unsigned EXP_WIDTH  = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter logic [31:0] LFSR_SEED  = 32'hACE1_5EED
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ld_en,
  input  logic [ADDR_WIDTH-1:0]           ld_addr,
  input  logic [STIM_WIDTH+EXP_WIDTH-1:0] ld_data,
  input  logic [ADDR_WIDTH:0]             cfg_num_vec,
  input  logic [15:0]                     cfg_num_rand,
  input  logic                            start,
  input  logic                            abort,
  output logic [STIM_WIDTH-1:0]           stim_out,
  output logic                            stim_valid,
  input  logic                            stim_ready,
  input  logic [EXP_WIDTH-1:0]            resp_in,
  output logic                            busy,
  output logic                            done,
  output logic                            err_pulse,
  output logic [15:0]                     err_count,
  output logic [15:0]                     vec_count,
  output logic [ADDR_WIDTH-1:0]           first_err_idx,
  output logic                            err_seen
);

  typedef enum logic [2:0] {S_IDLE, S_DIRECTED, S_RANDOM, S_DRAIN, S_DONE} state_t;

  localparam int unsigned        ENTRY_W   = STIM_WIDTH + EXP_WIDTH;
  localparam logic [31:0]        LFSR_MASK = 32'h8020_0003;
  localparam logic [ADDR_WIDTH:0] DEPTH_L  = (ADDR_WIDTH+1)'(DEPTH);

  logic [ENTRY_W-1:0]    mem_q [DEPTH];
  state_t                state_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [ADDR_WIDTH:0]   num_vec_q;
  logic [15:0]           num_rand_q;
  logic [15:0]           rand_cnt_q;
  logic [31:0]           lfsr_q;
  logic [STIM_WIDTH-1:0] stim_out_q;
  logic                  stim_valid_q;
  logic                  busy_q;
  logic                  done_q;
  logic [15:0]           err_count_q;
  logic [15:0]           vec_count_q;
  logic [ADDR_WIDTH-1:0] first_err_idx_q;
  logic                  err_seen_q;
  logic                  chk_pend_q;
  logic [EXP_WIDTH-1:0]  chk_exp_q;
  logic [ADDR_WIDTH-1:0] chk_idx_q;

  logic                  idle_like;
  logic                  start_ok;
  logic                  accept;
  logic                  mismatch;
  logic                  last_dir;
  logic                  last_rand;
  logic                  ld_addr_ok;
  logic [31:0]           lfsr_d;
  logic [ADDR_WIDTH-1:0] idx_d;
  logic [15:0]           rand_cnt_d;
  logic [ADDR_WIDTH:0]   num_vec_d;

  always_comb begin
    idle_like  = (state_q == S_IDLE) || (state_q == S_DONE);
    start_ok   = start && idle_like && !(abort && (state_q == S_IDLE));
    accept     = stim_valid_q && stim_ready && !abort;
    mismatch   = chk_pend_q && (resp_in != chk_exp_q);
    lfsr_d     = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_MASK : '0);
    idx_d      = idx_q + 1'b1;
    rand_cnt_d = rand_cnt_q + 16'd1;
    last_dir   = ({1'b0, idx_q} == (num_vec_q - 1'b1));
    last_rand  = (rand_cnt_d == num_rand_q);
    num_vec_d  = (cfg_num_vec > DEPTH_L) ? DEPTH_L : cfg_num_vec;
  end

  if (DEPTH < (1 << ADDR_WIDTH)) begin : g_partial_map
    assign ld_addr_ok = ({1'b0, ld_addr} < DEPTH_L);
  end else begin : g_full_map
    assign ld_addr_ok = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (ld_en && idle_like && ld_addr_ok) begin
      mem_q[ld_addr] <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= S_IDLE;
      idx_q           <= '0;
      num_vec_q       <= '0;
      num_rand_q      <= '0;
      rand_cnt_q      <= '0;
      lfsr_q          <= LFSR_SEED;
      stim_out_q      <= '0;
      stim_valid_q    <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      err_count_q     <= '0;
      vec_count_q     <= '0;
      first_err_idx_q <= '0;
      err_seen_q      <= 1'b0;
      chk_pend_q      <= 1'b0;
      chk_exp_q       <= '0;
      chk_idx_q       <= '0;
    end else begin
      // The previous cycle's check always completes, even across abort or drain.
      chk_pend_q <= 1'b0;
      if (mismatch) begin
        if (err_count_q != '1) err_count_q <= err_count_q + 16'd1;
        if (!err_seen_q) begin
          first_err_idx_q <= chk_idx_q;
          err_seen_q      <= 1'b1;
        end
      end
      if (accept && (vec_count_q != '1)) vec_count_q <= vec_count_q + 16'd1;

      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start_ok) begin
            done_q      <= 1'b0;
            err_count_q <= '0;
            vec_count_q <= '0;
            err_seen_q  <= 1'b0;
            lfsr_q      <= LFSR_SEED;
            num_vec_q   <= num_vec_d;
            num_rand_q  <= cfg_num_rand;
            idx_q       <= '0;
            rand_cnt_q  <= '0;
            if (num_vec_d != '0) begin
              state_q      <= S_DIRECTED;
              busy_q       <= 1'b1;
              stim_valid_q <= 1'b1;
              stim_out_q   <= mem_q[0][ENTRY_W-1:EXP_WIDTH];
            end else if (cfg_num_rand != '0) begin
              state_q      <= S_RANDOM;
              busy_q       <= 1'b1;
              stim_valid_q <= 1'b1;
              stim_out_q   <= LFSR_SEED[STIM_WIDTH-1:0];
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        S_DIRECTED: begin
          if (abort) begin
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
            stim_valid_q <= 1'b0;
          end else if (accept) begin
            chk_pend_q <= 1'b1;
            chk_exp_q  <= mem_q[idx_q][EXP_WIDTH-1:0];
            chk_idx_q  <= idx_q;
            idx_q      <= idx_d;
            if (!last_dir) begin
              stim_out_q <= mem_q[idx_d][ENTRY_W-1:EXP_WIDTH];
            end else if (num_rand_q != '0) begin
              state_q    <= S_RANDOM;
              stim_out_q <= lfsr_q[STIM_WIDTH-1:0];
            end else begin
              state_q      <= S_DRAIN;
              stim_valid_q <= 1'b0;
            end
          end
        end
        S_RANDOM: begin
          if (abort) begin
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
            stim_valid_q <= 1'b0;
          end else if (accept) begin
            lfsr_q     <= lfsr_d;
            rand_cnt_q <= rand_cnt_d;
            if (last_rand) begin
              state_q      <= S_DRAIN;
              stim_valid_q <= 1'b0;
            end else begin
              stim_out_q <= lfsr_d[STIM_WIDTH-1:0];
            end
          end
        end
        S_DRAIN: begin
          busy_q <= 1'b0;
          if (abort) begin
            state_q <= S_IDLE;
          end else begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign stim_out      = stim_out_q;
  assign stim_valid    = stim_valid_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err_pulse     = mismatch;
  assign err_count     = err_count_q;
  assign vec_count     = vec_count_q;
  assign first_err_idx = first_err_idx_q;
  assign err_seen      = err_seen_q;

endmodule

// File: doc/vector_player_checker.md
Name: vector_player_checker

Overview:
- Synthesizable stimulus player and response checker, parametrised in vector width, memory depth and run mode.
- Replays a loaded table of directed vectors, each with an expected response, into a block under test and checks every response.
- After the directed table, issues a configurable count of LFSR pseudo-random vectors.
- Counts vectors issued and mismatches, and records the first failing index; used for on-chip and FPGA self-test.

Parameters:
- STIM_WIDTH, 15, stimulus vector width (1..32)
- EXP_WIDTH, 8, expected/response width
- DEPTH, 16, directed vector memory entries
- ADDR_WIDTH, 4, memory address width; must be >= clog2(DEPTH)
- LFSR_SEED, 32'hACE1_5EED, LFSR reset and restart value; must be nonzero

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- ld_en  in  1  memory write strobe
- ld_addr  in  ADDR_WIDTH  memory write address
- ld_data  in  STIM_WIDTH+EXP_WIDTH  {stim, expected} entry
- cfg_num_vec  in  ADDR_WIDTH+1  directed vectors to play, sampled at start
- cfg_num_rand  in  16  random vectors to play, sampled at start
- start  in  1  run request pulse
- abort  in  1  stop the run
- stim_out  out  STIM_WIDTH  stimulus to the block under test
- stim_valid  out  1  stim_out is valid
- stim_ready  in  1  block under test accepts stim_out
- resp_in  in  EXP_WIDTH  response from the block under test
- busy  out  1  run in progress
- done  out  1  run completed normally
- err_pulse  out  1  one-cycle pulse per mismatch
- err_count  out  16  mismatch count, saturating
- vec_count  out  16  accepted vectors, saturating
- first_err_idx  out  ADDR_WIDTH  index of the first mismatch
- err_seen  out  1  first_err_idx is valid

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0; LFSR=LFSR_SEED; memory contents undefined.
- States: IDLE, DIRECTED, RANDOM, DRAIN, DONE. busy=1 in DIRECTED, RANDOM and DRAIN.
- Memory load:
  - ld_en writes mem[ld_addr] only in IDLE or DONE; ignored while busy.
  - ld_addr >= DEPTH is ignored.
- start, in IDLE or DONE only:
  - Clears done, err_count, vec_count and err_seen; reseeds the LFSR; latches both cfg_ values.
  - Next state is DIRECTED if num_vec>0, else RANDOM if num_rand>0, else DONE.
  - start while busy is ignored.
  - num_vec > DEPTH is clamped to DEPTH.
- A vector is accepted when stim_valid&&stim_ready. stim_out holds stable while stim_valid=1 and stim_ready=0.
- DIRECTED:
  - stim_valid=1 and stim_out=mem[idx][STIM_WIDTH+EXP_WIDTH-1:EXP_WIDTH]; idx starts at 0.
  - On accept, idx increments. After the accept with idx=num_vec-1, go to RANDOM if num_rand>0, else DRAIN.
- Response check:
  - resp_in is sampled exactly one cycle after each directed accept and compared against that vector's expected field.
  - On mismatch: err_pulse=1 for that cycle and err_count increments.
  - If err_seen=0, first_err_idx takes the failing index and err_seen goes to 1.
  - Random vectors are never checked.
- RANDOM:
  - stim_out=LFSR[STIM_WIDTH-1:0], stim_valid=1.
  - LFSR is 32-bit Galois, mask 32'h8020_0003, shift right; it advances only on accept.
  - After num_rand accepts, go to DRAIN.
- DRAIN: stim_valid=0 for exactly one cycle so the last directed check completes; then DONE with done=1 held until the next start.
- vec_count increments on every accept, directed or random.
- Both counters saturate at 16'hFFFF.
- abort in DIRECTED, RANDOM or DRAIN:
  - Next state is IDLE with stim_valid=0, done stays 0, counters are frozen.
  - A check pending from the previous cycle still completes.
- Simultaneous start and abort in IDLE: abort wins and the state stays IDLE.
- Reset mid-run returns immediately to the reset values.

Test Plan:
- Load 4 entries with correct expected values, num_vec=4, num_rand=0, stim_ready=1, with an echo model (resp = expected) → 4 stim beats; done asserted 6 cycles after start; err_count=0, vec_count=4, err_seen=0.
- Corrupt the expected field of entry 2 → exactly one err_pulse, 1 cycle after the beat-2 accept; err_count=1, first_err_idx=2, err_seen=1.
- num_vec=0, num_rand=3 → stim_out=LFSR_SEED[14:0] on the first beat, then the next two Galois states; vec_count=3, err_count=0.
- Hold stim_ready=0 for 5 cycles on directed beat 1 → stim_out stable over those cycles, vec_count unchanged, no check issued until the accept.
- Assert abort during RANDOM after 2 accepts → IDLE next cycle, stim_valid=0, done=0, vec_count frozen at num_vec+2.
- Drive rst low mid-DIRECTED → all outputs 0 asynchronously; a new start after reset replays from idx 0.
